desc_word_sender: RTL and testbench

Producer side of the NCC descriptor-load interface. It accepts one 8-bit descriptor pixel per handshake from the descriptor source and packs four consecutive pixels into one 32-bit word, first pixel in bits [31:24]. Packed words are buffered in a small FIFO and presented on `desc_data_out` with a `desc_data_ready`/`desc_data_ack` handshake. The NCC descriptor loader consumes one word per handshake, 64 words per 16x16 descriptor.

---
 rtl/desc_word_sender.sv | 150 +++++++++++++++
 tb/tb_desc_word_sender.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/desc_word_sender.sv
// Descriptor pixel packer: four 8-bit pixels per 32-bit word, first pixel in the MSB byte,
// buffered in a small FIFO and handed to the NCC descriptor loader one word per ack.
//
// state  | meaning
// IDLE   | waiting for desc_start, no words held
// ACTIVE | accepting pixels and packing words
// FLUSH  | all pixels taken, draining remaining words
// DONE   | last word acked, desc_sent pulse
module desc_word_sender #(
    parameter int PIXELS_PER_DESC = 256,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        desc_start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [31:0] desc_data_out,
    output logic        desc_data_ready,
    input  logic        desc_data_ack,
    output logic [3:0]  sent_row,
    output logic [1:0]  sent_col,
    output logic        desc_sent,
    output logic        busy,
    output logic        ack_err
);

    localparam int WORDS = PIXELS_PER_DESC / 4;
    localparam int PW    = $clog2(PIXELS_PER_DESC);
    localparam int SW    = ($clog2(WORDS) + 1 < 6) ? 6 : $clog2(WORDS) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} state_t;

    state_t          state_q;
    logic [PW-1:0]   pix_cnt_q;
    logic [1:0]      lane_q;
    logic [23:0]     pack_q;
    logic [SW-1:0]   sent_cnt_q;
    logic            ack_err_q;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;
    logic stray;
    logic last_pop;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pix_ready  = (state_q == ACTIVE) && !fifo_full;
    assign accept     = pix_valid && pix_ready;
    assign push       = accept && (lane_q == 2'd3);
    assign pop        = desc_data_ack && !fifo_empty;
    assign stray      = desc_data_ack && fifo_empty;
    assign last_pop   = pop && (sent_cnt_q == SW'(WORDS - 1));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pix_cnt_q  <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            sent_cnt_q <= '0;
            ack_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (desc_start) begin
                        state_q    <= ACTIVE;
                        pix_cnt_q  <= '0;
                        sent_cnt_q <= '0;
                        lane_q     <= '0;
                        pack_q     <= '0;
                        ack_err_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        pix_cnt_q <= pix_cnt_q + 1'b1;
                        lane_q    <= lane_q + 2'd1;
                        case (lane_q)
                            2'd0:    pack_q[23:16] <= pix_data;
                            2'd1:    pack_q[15:8]  <= pix_data;
                            2'd2:    pack_q[7:0]   <= pix_data;
                            default: pack_q        <= pack_q;
                        endcase
                        if (pix_cnt_q == PW'(PIXELS_PER_DESC - 1)) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: state_q <= FLUSH;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // a stray ack at the same edge as a start still leaves the error visible
            if (stray) begin
                ack_err_q <= 1'b1;
            end

            if (pop) begin
                sent_cnt_q <= sent_cnt_q + 1'b1;
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                if (last_pop) begin
                    state_q <= DONE;
                end
            end

            if (push) begin
                mem_q[wr_ptr_q] <= {pack_q, pix_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end

            count_q <= count_d;
        end
    end

    assign desc_data_out   = mem_q[rd_ptr_q];
    assign desc_data_ready = !fifo_empty;
    assign sent_row        = sent_cnt_q[5:2];
    assign sent_col        = sent_cnt_q[1:0];
    assign desc_sent       = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign ack_err         = ack_err_q;

endmodule

// File: tb/tb_desc_word_sender.sv
// Directed bench for desc_word_sender: reset, full-rate and half-rate descriptors,
// back-pressure, stray ack, ignored restart and mid-descriptor reset.
module tb_desc_word_sender;

    logic        clk;
    logic        rst;
    logic        desc_start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic [31:0] desc_data_out;
    logic        desc_data_ready;
    logic        desc_data_ack;
    logic [3:0]  sent_row;
    logic [1:0]  sent_col;
    logic        desc_sent;
    logic        busy;
    logic        ack_err;

    int n_vec = 0;
    int n_err = 0;

    desc_word_sender #(
        .PIXELS_PER_DESC(256),
        .FIFO_DEPTH(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .desc_start      (desc_start),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .desc_data_out   (desc_data_out),
        .desc_data_ready (desc_data_ready),
        .desc_data_ack   (desc_data_ack),
        .sent_row        (sent_row),
        .sent_col        (sent_col),
        .desc_sent       (desc_sent),
        .busy            (busy),
        .ack_err         (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_desc();
        desc_start = 1'b1;
        tick();
        desc_start = 1'b0;
    endtask

    // Streams pixels p_start..255 (value = base + index) and acks every 'per' cycles
    // until all 64 words are taken, checking each word and its row/col on the ack cycle.
    task automatic stream(input int p_start, input int k_start, input int per, input logic [7:0] base);
        int p;
        int k;
        int cyc;
        logic acc;
        logic ackd;
        logic flush_seen;
        logic [7:0] b;
        p = p_start;
        k = k_start;
        cyc = 0;
        flush_seen = 1'b0;
        while (k < 64 && cyc < 3000) begin
            pix_valid = (p < 256);
            pix_data  = base + 8'(p);
            desc_data_ack = 1'b0;
            if ((cyc % per) == 0 && desc_data_ready) begin
                b = base + 8'(4 * k);
                check("word", desc_data_out, {b, b + 8'd1, b + 8'd2, b + 8'd3});
                check("rowcol", {26'd0, sent_row, sent_col}, 32'(k[5:0]));
                desc_data_ack = 1'b1;
            end
            if (p == 256 && !flush_seen) begin
                check("flush_pix_ready", pix_ready, 1'b0);
                flush_seen = 1'b1;
            end
            acc  = pix_valid && pix_ready;
            ackd = desc_data_ack;
            tick();
            if (acc) p++;
            if (ackd) k++;
            cyc++;
        end
        pix_valid     = 1'b0;
        desc_data_ack = 1'b0;
        check("words_acked", k, 64);
        check("desc_sent_pulse", desc_sent, 1'b1);
        check("busy_in_done", busy, 1'b1);
        check("ready_after_last", desc_data_ready, 1'b0);
        tick();
        check("desc_sent_once", desc_sent, 1'b0);
        check("busy_drop", busy, 1'b0);
    endtask

    int n;
    int cyc;

    initial begin
        rst           = 1'b0;
        desc_start    = 1'b0;
        pix_valid     = 1'b0;
        pix_data      = 8'h00;
        desc_data_ack = 1'b0;

        // reset values
        #2;
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_data_out", desc_data_out, 32'h0);
        check("rst_data_ready", desc_data_ready, 1'b0);
        check("rst_rowcol", {sent_row, sent_col}, 6'd0);
        check("rst_desc_sent", desc_sent, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        #10 rst = 1'b1;
        tick(); tick(); tick();
        check("idle_hold_busy", busy, 1'b0);
        check("idle_hold_pix_ready", pix_ready, 1'b0);
        check("idle_hold_ready", desc_data_ready, 1'b0);

        // full descriptor, ack every other cycle
        start_desc();
        check("start_busy", busy, 1'b1);
        check("start_pix_ready", pix_ready, 1'b1);
        stream(0, 0, 2, 8'h00);

        // stray ack on an empty FIFO
        start_desc();
        check("stray_pre_err", ack_err, 1'b0);
        desc_data_ack = 1'b1;
        tick();
        desc_data_ack = 1'b0;
        check("stray_ack_err", ack_err, 1'b1);
        check("stray_rowcol", {sent_row, sent_col}, 6'd0);
        check("stray_ready", desc_data_ready, 1'b0);
        check("stray_busy", busy, 1'b1);

        // ignored restart after 5 pixels, then finish the descriptor
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(i);
            tick();
        end
        pix_valid  = 1'b0;
        desc_start = 1'b1;
        tick();
        desc_start = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_pix_ready", pix_ready, 1'b1);
        check("restart_word0", desc_data_out, 32'h00010203);
        check("restart_rowcol", {sent_row, sent_col}, 6'd0);
        stream(5, 0, 2, 8'h00);
        check("err_sticky", ack_err, 1'b1);

        // back-pressure; this start also clears ack_err
        start_desc();
        check("start_clears_err", ack_err, 1'b0);
        n = 0;
        cyc = 0;
        pix_valid = 1'b1;
        while (pix_ready && cyc < 40) begin
            pix_data = 8'(n);
            tick();
            n++;
            cyc++;
        end
        check("bp_accepted", n, 16);
        check("bp_ready", desc_data_ready, 1'b1);
        check("bp_word0", desc_data_out, 32'h00010203);
        desc_data_ack = 1'b1;
        tick();
        desc_data_ack = 1'b0;
        check("bp_pix_ready_after_pop", pix_ready, 1'b1);
        cyc = 0;
        while (pix_ready && cyc < 20) begin
            pix_data = 8'(n);
            tick();
            n++;
            cyc++;
        end
        check("bp_refill", n, 20);
        pix_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            check("bp_drain_word", desc_data_out,
                  {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
            desc_data_ack = 1'b1;
            tick();
            desc_data_ack = 1'b0;
        end
        check("bp_drained", desc_data_ready, 1'b0);
        check("bp_rowcol", {sent_row, sent_col}, 6'd5);
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        check("bp_reset_idle", busy, 1'b0);

        // reset mid-descriptor after 10 pixels and one ack
        start_desc();
        for (int i = 0; i < 10; i++) begin
            pix_valid     = 1'b1;
            pix_data      = 8'(i);
            desc_data_ack = (i == 6);
            if (i == 6) check("mid_ready", desc_data_ready, 1'b1);
            tick();
        end
        pix_valid     = 1'b0;
        desc_data_ack = 1'b0;
        check("mid_rowcol", {sent_row, sent_col}, 6'd1);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_ready", desc_data_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pix_ready", pix_ready, 1'b0);
        check("mid_rst_data", desc_data_out, 32'h0);
        check("mid_rst_rowcol", {sent_row, sent_col}, 6'd0);
        #1 rst = 1'b1;
        tick();
        check("mid_post_busy", busy, 1'b0);
        check("mid_post_ready", desc_data_ready, 1'b0);
        start_desc();
        stream(0, 0, 1, 8'hA0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
